// File: rtl/rv32i_types_pkg.sv
// rtl/rv32i_types_pkg.sv - shared RV32 pipeline types: hazard FSM states, next-PC select, stall fill helper
package rv32i_types_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        WAIT_MEM = 2'b01,
        TRAP     = 2'b10,
        HALTED   = 2'b11
    } hazard_state_t;

    typedef enum logic [1:0] {
        NPC_SEQ  = 2'b00,
        NPC_TGT  = 2'b01,
        NPC_TRAP = 2'b10,
        NPC_EPC  = 2'b11
    } npc_sel_t;

    // A stall request at stage k must also hold every younger stage below it.
    function automatic logic [7:0] stall_fill(input logic [7:0] req);
        logic [7:0] res;
        res[7] = req[7];
        for (int j = 6; j >= 0; j--) begin
            res[j] = res[j+1] | req[j];
        end
        return res;
    endfunction

endpackage

// File: rtl/hazard_trap_fsm.sv
// rtl/hazard_trap_fsm.sv - trap sequencing / halt FSM with registered EPC and trapping-stage index
module hazard_trap_fsm
    import rv32i_types_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int XLEN       = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          d_ram_busy,
    input  logic                          halt,
    input  logic                          interrupt,
    input  logic [NUM_STAGES-1:0]         exc_vec,
    input  logic [NUM_STAGES*XLEN-1:0]    epc_vec,
    output logic                          insert_pc,
    output logic                          hold_all,
    output logic                          halted,
    output logic [XLEN-1:0]               epc_out,
    output logic [$clog2(NUM_STAGES)-1:0] exc_stage
);

    localparam int SW = $clog2(NUM_STAGES);

    hazard_state_t   state_q, state_d;
    logic            trap_pending;
    logic [SW-1:0]   cand_idx;
    logic [XLEN-1:0] cand_epc;

    assign trap_pending = (|exc_vec) | interrupt;

    // Oldest (highest-index) excepting stage wins; a bare interrupt is taken at the commit stage.
    always_comb begin
        cand_idx = SW'(NUM_STAGES - 1);
        cand_epc = epc_vec[(NUM_STAGES-1)*XLEN +: XLEN];
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (exc_vec[k]) begin
                cand_idx = SW'(k);
                cand_epc = epc_vec[k*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN: begin
                if (trap_pending) begin
                    state_d = d_ram_busy ? WAIT_MEM : TRAP;
                end else if (halt && !d_ram_busy) begin
                    state_d = HALTED;
                end
            end
            WAIT_MEM: if (!d_ram_busy) state_d = TRAP;
            TRAP:     state_d = RUN;
            HALTED:   state_d = HALTED;
            default:  state_d = RUN;
        endcase
    end

    always_comb begin
        insert_pc = 1'b0;
        hold_all  = 1'b0;
        halted    = 1'b0;
        case (state_q)
            RUN:      hold_all = trap_pending;
            WAIT_MEM: hold_all = 1'b1;
            TRAP:     insert_pc = 1'b1;
            HALTED: begin
                hold_all = 1'b1;
                halted   = 1'b1;
            end
            default: ;
        endcase
    end

    // Candidate is captured once, on leaving RUN; exc_vec is ignored while draining.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            epc_out   <= '0;
            exc_stage <= '0;
        end else if (state_q == RUN && trap_pending) begin
            epc_out   <= cand_epc;
            exc_stage <= cand_idx;
        end
    end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - N-stage stall/flush/redirect controller; HAZARD_PERF_CNT_EN adds perf counters
module pipeline_hazard_unit
    import rv32i_types_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int XLEN       = 32
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_W      = 32
`endif
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          i_ram_busy,
    input  logic                          d_ram_busy,
    input  logic                          dren,
    input  logic                          dwen,
    input  logic                          mispredict,
    input  logic                          halt,
    input  logic                          ret,
    input  logic                          interrupt,
    input  logic [NUM_STAGES-1:0]         exc_vec,
    input  logic [NUM_STAGES*XLEN-1:0]    epc_vec,
    input  logic                          load_in_ex,
    input  logic [4:0]                    ex_rd,
    input  logic [4:0]                    id_rs1,
    input  logic [4:0]                    id_rs2,
    output logic                          pc_en,
    output logic [1:0]                    npc_sel,
    output logic [NUM_STAGES-1:0]         stage_stall,
    output logic [NUM_STAGES-1:0]         stage_flush,
    output logic                          insert_pc,
    output logic [XLEN-1:0]               epc_out,
    output logic [$clog2(NUM_STAGES)-1:0] exc_stage,
    output logic                          halted
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]              stall_cycles,
    output logic [CNT_W-1:0]              flush_events
`endif
);

    localparam int EX_IDX = NUM_STAGES - 1;
    localparam logic [NUM_STAGES-1:0] FLUSH_FRONT = {1'b0, {EX_IDX{1'b1}}};

    logic                  hold_all;
    logic                  load_use;
    logic                  redirect;
    logic [NUM_STAGES-1:0] stall_raw;
    npc_sel_t              npc;
    logic                  unused_inputs;

    // Completion is signalled by d_ram_busy alone; the issue strobes carry no extra hazard information.
    assign unused_inputs = &{1'b0, dren, dwen};

    hazard_trap_fsm #(
        .NUM_STAGES (NUM_STAGES),
        .XLEN       (XLEN)
    ) u_trap_fsm (
        .CLK        (CLK),
        .RST        (RST),
        .d_ram_busy (d_ram_busy),
        .halt       (halt),
        .interrupt  (interrupt),
        .exc_vec    (exc_vec),
        .epc_vec    (epc_vec),
        .insert_pc  (insert_pc),
        .hold_all   (hold_all),
        .halted     (halted),
        .epc_out    (epc_out),
        .exc_stage  (exc_stage)
    );

    generate
        if (NUM_STAGES >= 3) begin : g_load_use
            assign load_use = load_in_ex && (ex_rd != 5'd0) &&
                              ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        end else begin : g_no_load_use
            assign load_use = 1'b0;
        end
    endgenerate

    assign redirect = (mispredict || ret) && !d_ram_busy;
    assign npc_sel  = npc;

    always_comb begin
        stall_raw   = '0;
        stage_stall = '0;
        stage_flush = '0;
        pc_en       = 1'b1;
        npc         = NPC_SEQ;
        if (!RST) begin
            if (insert_pc) begin
                stage_flush = '1;
                npc         = NPC_TRAP;
            end else if (hold_all) begin
                stage_stall = '1;
                pc_en       = 1'b0;
            end else if (redirect) begin
                stage_flush = FLUSH_FRONT;
                npc         = mispredict ? NPC_TGT : NPC_EPC;
            end else begin
                if (d_ram_busy) stall_raw = '1;
                if (load_use)   stall_raw[EX_IDX-1] = 1'b1;
                if (i_ram_busy) stall_raw[0] = 1'b1;
                stage_stall = NUM_STAGES'(stall_fill(8'(stall_raw)));
                // A bubble enters directly above the highest held stage.
                for (int k = 0; k < EX_IDX; k++) begin
                    stage_flush[k+1] = stage_stall[k] & ~stage_stall[k+1];
                end
                pc_en = ~stage_stall[0];
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stage_stall[0] && (stall_cycles != '1)) stall_cycles <= stall_cycles + 1'b1;
            if ((|stage_flush) && (flush_events != '1)) flush_events <= flush_events + 1'b1;
        end
    end
`endif

endmodule
